// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver: 2-flop synchroniser, 3-sample mid-bit majority vote,
// optional parity, 1 or 2 stop bits, and a valid/ready output with overrun pulse.
module uart_rx_cfg #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD      = 9600,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 uart_rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);
    localparam int BAUD_DIV = CLK_FREQ / BAUD;
    localparam int MID      = BAUD_DIV / 2;
    localparam int CNT_W    = $clog2(BAUD_DIV);

    localparam logic [CNT_W-1:0] CNT_S0   = CNT_W'(MID - 1);
    localparam logic [CNT_W-1:0] CNT_S1   = CNT_W'(MID);
    localparam logic [CNT_W-1:0] CNT_VOTE = CNT_W'(MID + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [3:0]       IDX_LAST  = 4'(DATA_BITS - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic             PAR_ODD   = (PARITY == 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PAR,
        ST_STOP,
        ST_DONE
    } state_t;

    state_t                 state_reg,    state_next;
    logic [1:0]             sync_reg;
    logic                   hist_reg;
    logic [CNT_W-1:0]       cnt_reg,      cnt_next;
    logic [1:0]             samp_reg,     samp_next;
    logic [3:0]             idx_reg,      idx_next;
    logic                   stop_idx_reg, stop_idx_next;
    logic [DATA_BITS-1:0]   shift_reg,    shift_next;
    logic                   fe_pend_reg,  fe_pend_next;
    logic                   pe_pend_reg,  pe_pend_next;
    logic [DATA_BITS-1:0]   data_reg,     data_next;
    logic                   valid_reg,    valid_next;
    logic                   ferr_reg,     ferr_next;
    logic                   perr_reg,     perr_next;
    logic                   ovr_reg,      ovr_next;

    logic                   line_s;
    logic                   start_edge;
    logic                   vote;
    logic                   vote_now;
    logic                   bit_end;
    logic [DATA_BITS:0]     par_chain;

    assign line_s     = sync_reg[1];
    assign start_edge = hist_reg & ~line_s;
    assign vote_now   = (cnt_reg == CNT_VOTE);
    assign bit_end    = (cnt_reg == CNT_LAST);
    // Third sample is taken live at MID+1, so the vote resolves in that same cycle.
    assign vote = (samp_reg[0] & samp_reg[1]) | (samp_reg[0] & line_s) | (samp_reg[1] & line_s);

    assign par_chain[0] = 1'b0;
    generate
        for (genvar gi = 0; gi < DATA_BITS; gi++) begin : g_par
            assign par_chain[gi+1] = par_chain[gi] ^ shift_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            sync_reg     <= 2'b11;
            hist_reg     <= 1'b1;
            cnt_reg      <= '0;
            samp_reg     <= 2'b11;
            idx_reg      <= '0;
            stop_idx_reg <= 1'b0;
            shift_reg    <= '0;
            fe_pend_reg  <= 1'b0;
            pe_pend_reg  <= 1'b0;
            data_reg     <= '0;
            valid_reg    <= 1'b0;
            ferr_reg     <= 1'b0;
            perr_reg     <= 1'b0;
            ovr_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            sync_reg     <= {sync_reg[0], uart_rx};
            hist_reg     <= line_s;
            cnt_reg      <= cnt_next;
            samp_reg     <= samp_next;
            idx_reg      <= idx_next;
            stop_idx_reg <= stop_idx_next;
            shift_reg    <= shift_next;
            fe_pend_reg  <= fe_pend_next;
            pe_pend_reg  <= pe_pend_next;
            data_reg     <= data_next;
            valid_reg    <= valid_next;
            ferr_reg     <= ferr_next;
            perr_reg     <= perr_next;
            ovr_reg      <= ovr_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = bit_end ? '0 : cnt_reg + CNT_W'(1);
        samp_next     = samp_reg;
        idx_next      = idx_reg;
        stop_idx_next = stop_idx_reg;
        shift_next    = shift_reg;
        fe_pend_next  = fe_pend_reg;
        pe_pend_next  = pe_pend_reg;
        data_next     = data_reg;
        valid_next    = valid_reg;
        ferr_next     = ferr_reg;
        perr_next     = perr_reg;
        ovr_next      = 1'b0;

        if (cnt_reg == CNT_S0) samp_next[0] = line_s;
        if (cnt_reg == CNT_S1) samp_next[1] = line_s;

        if (valid_reg && rx_ready) valid_next = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (start_edge) begin
                    state_next    = ST_START;
                    idx_next      = '0;
                    stop_idx_next = 1'b0;
                    fe_pend_next  = 1'b0;
                    pe_pend_next  = 1'b0;
                end
            end
            ST_START: begin
                if (vote_now && vote) state_next = ST_IDLE;
                else if (bit_end)     state_next = ST_DATA;
            end
            ST_DATA: begin
                if (vote_now) shift_next = {vote, shift_reg[DATA_BITS-1:1]};
                if (bit_end) begin
                    if (idx_reg == IDX_LAST) state_next = (PARITY != 0) ? ST_PAR : ST_STOP;
                    else                     idx_next   = idx_reg + 4'd1;
                end
            end
            ST_PAR: begin
                if (vote_now) pe_pend_next = par_chain[DATA_BITS] ^ vote ^ PAR_ODD;
                if (bit_end)  state_next   = ST_STOP;
            end
            ST_STOP: begin
                // Leave on the last vote rather than at bit end so a back-to-back start is seen.
                if (vote_now) begin
                    if (!vote) fe_pend_next = 1'b1;
                    if (stop_idx_reg == STOP_LAST) state_next = ST_DONE;
                end else if (bit_end) begin
                    stop_idx_next = stop_idx_reg + 1'b1;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
                if (!valid_reg || rx_ready) begin
                    valid_next = 1'b1;
                    data_next  = shift_reg;
                    ferr_next  = fe_pend_reg;
                    perr_next  = pe_pend_reg;
                end else begin
                    ovr_next = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        if (state_next != state_reg) cnt_next = '0;
    end

    assign rx_data    = data_reg;
    assign rx_valid   = valid_reg;
    assign frame_err  = ferr_reg;
    assign parity_err = perr_reg;
    assign overrun    = ovr_reg;
    assign busy       = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: three configurations (8N1, 7E1, 8N2) checked each cycle
// against a frame-level handshake model, plus hand-computed literal checks.
`timescale 1ns/1ps
module tb_uart_rx_cfg;
    localparam int BD = 10;

    typedef struct {
        int         inst;
        int         land;
        logic [8:0] data;
        logic       fe;
        logic       pe;
    } pend_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic line [3] = '{default: 1'b1};
    logic rdy  [3] = '{default: 1'b1};
    logic [7:0] d0;
    logic [6:0] d1;
    logic [7:0] d2;
    logic [8:0] dd  [3];
    logic vld [3];
    logic fe  [3];
    logic pe  [3];
    logic ovr [3];
    logic bsy [3];

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    pend_t      pq [$];
    logic       m_vld  [3] = '{default: 1'b0};
    logic       m_fe   [3] = '{default: 1'b0};
    logic       m_pe   [3] = '{default: 1'b0};
    logic       m_ovr  [3] = '{default: 1'b0};
    logic [8:0] m_data [3] = '{default: 9'h0};

    always #5 clk = ~clk;

    assign dd[0] = {1'b0, d0};
    assign dd[1] = {2'b0, d1};
    assign dd[2] = {1'b0, d2};

    uart_rx_cfg #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .rst(rst), .uart_rx(line[0]), .rx_data(d0), .rx_valid(vld[0]), .rx_ready(rdy[0]),
        .frame_err(fe[0]), .parity_err(pe[0]), .overrun(ovr[0]), .busy(bsy[0]));
    uart_rx_cfg #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) u_7e1 (
        .clk(clk), .rst(rst), .uart_rx(line[1]), .rx_data(d1), .rx_valid(vld[1]), .rx_ready(rdy[1]),
        .frame_err(fe[1]), .parity_err(pe[1]), .overrun(ovr[1]), .busy(bsy[1]));
    uart_rx_cfg #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_8n2 (
        .clk(clk), .rst(rst), .uart_rx(line[2]), .rx_data(d2), .rx_valid(vld[2]), .rx_ready(rdy[2]),
        .frame_err(fe[2]), .parity_err(pe[2]), .overrun(ovr[2]), .busy(bsy[2]));

    function automatic int db(input int i);
        return (i == 1) ? 7 : 8;
    endfunction
    function automatic int par(input int i);
        return (i == 1) ? 2 : 0;
    endfunction
    function automatic int ns(input int i);
        return (i == 2) ? 2 : 1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Model: a frame of N bits whose start bit is first sampled at cycle k delivers its word at cycle k+BD*N.
    always @(posedge clk) begin
        cyc = cyc + 1;
        for (int i = 0; i < 3; i++) begin
            bit acc;
            acc = m_vld[i] && rdy[i];
            m_ovr[i] = 1'b0;
            if (rst) begin
                m_vld[i] = 1'b0; m_data[i] = '0; m_fe[i] = 1'b0; m_pe[i] = 1'b0;
            end else if (pq.size() > 0 && pq[0].inst == i && pq[0].land == cyc) begin
                if (!m_vld[i] || acc) begin
                    m_vld[i] = 1'b1; m_data[i] = pq[0].data; m_fe[i] = pq[0].fe; m_pe[i] = pq[0].pe;
                end else begin
                    m_ovr[i] = 1'b1;
                end
                void'(pq.pop_front());
            end else if (acc) begin
                m_vld[i] = 1'b0;
            end
        end
        if (rst) pq.delete();
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rx_valid%0d", i), 32'(vld[i]), 32'(m_vld[i]));
            chk($sformatf("rx_data%0d", i), 32'(dd[i]), 32'(m_data[i]));
            chk($sformatf("frame_err%0d", i), 32'(fe[i]), 32'(m_fe[i]));
            chk($sformatf("parity_err%0d", i), 32'(pe[i]), 32'(m_pe[i]));
            chk($sformatf("overrun%0d", i), 32'(ovr[i]), 32'(m_ovr[i]));
            if (vld[i] === 1'b1 && rdy[i] === 1'b1)
                $display("rx%0d word=%h frame_err=%b parity_err=%b cycle=%0d", i, dd[i], fe[i], pe[i], cyc);
        end
    end

    task automatic hold_bit(input int i, input logic b, input bit g);
        line[i] = b;
        for (int t = 1; t < BD; t++) begin
            @(negedge clk);
            if (g && t == 6)      line[i] = ~b;
            else if (g && t == 7) line[i] = b;
        end
    endtask

    task automatic send_frame(input int i, input logic [8:0] data, input logic pbit,
                              input logic [1:0] stops, input bit push, input int gbit);
        int         k;
        int         n;
        pend_t      p;
        logic [8:0] dm;
        dm = data & ((9'h1 << db(i)) - 9'h1);
        n  = 1 + db(i) + ((par(i) != 0) ? 1 : 0) + ns(i);
        @(negedge clk);
        k = cyc + 1;
        if (push) begin
            p.inst = i;
            p.land = k + BD * n;
            p.data = dm;
            p.fe   = !stops[0] || (ns(i) == 2 && !stops[1]);
            p.pe   = (par(i) == 0) ? 1'b0 : (((^dm) ^ pbit) != (par(i) == 1));
            pq.push_back(p);
        end
        hold_bit(i, 1'b0, 1'b0);
        for (int b = 0; b < db(i); b++) begin
            @(negedge clk);
            hold_bit(i, dm[b], gbit == b);
        end
        if (par(i) != 0) begin
            @(negedge clk);
            hold_bit(i, pbit, 1'b0);
        end
        for (int s = 0; s < ns(i); s++) begin
            @(negedge clk);
            hold_bit(i, stops[s], 1'b0);
        end
        @(negedge clk);
        line[i] = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int nb;
        int nv;
        repeat (3) @(negedge clk);
        chk("reset_valid", 32'(vld[0]), 0);
        chk("reset_data", 32'(dd[0]), 0);
        chk("reset_busy", 32'(bsy[0]), 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // 8N1 0xA5: word appears exactly one cycle after the frame ends, for one cycle
        send_frame(0, 9'h0A5, 1'b0, 2'b11, 1'b1, -1);
        chk("a5_not_early", 32'(vld[0]), 0);
        chk("a5_busy_done", 32'(bsy[0]), 1);
        @(negedge clk);
        chk("a5_valid", 32'(vld[0]), 1);
        chk("a5_data", 32'(dd[0]), 'hA5);
        chk("a5_flags", 32'({fe[0], pe[0], ovr[0]}), 0);
        @(negedge clk);
        chk("a5_valid_fall", 32'(vld[0]), 0);
        chk("a5_idle", 32'(bsy[0]), 0);

        // 7E1 0x35 (four ones): parity bit 1 is wrong, 0 is right
        repeat (3) @(negedge clk);
        send_frame(1, 9'h035, 1'b1, 2'b11, 1'b1, -1);
        @(negedge clk);
        chk("par_bad_err", 32'(pe[1]), 1);
        chk("par_bad_data", 32'(dd[1]), 'h35);
        repeat (3) @(negedge clk);
        send_frame(1, 9'h035, 1'b0, 2'b11, 1'b1, -1);
        @(negedge clk);
        chk("par_ok_err", 32'(pe[1]), 0);
        chk("par_ok_data", 32'(dd[1]), 'h35);

        // 8N2: second stop bit low, then a clean frame
        repeat (3) @(negedge clk);
        send_frame(2, 9'h03C, 1'b0, 2'b01, 1'b1, -1);
        @(negedge clk);
        chk("stop2_ferr", 32'(fe[2]), 1);
        chk("stop2_data", 32'(dd[2]), 'h3C);
        repeat (3) @(negedge clk);
        send_frame(2, 9'h081, 1'b0, 2'b11, 1'b1, -1);
        @(negedge clk);
        chk("stop2_clear", 32'(fe[2]), 0);
        chk("stop2_data2", 32'(dd[2]), 'h81);

        // False start: line low for only 3 cycles
        repeat (3) @(negedge clk);
        @(negedge clk);
        line[0] = 1'b0;
        nb = 0;
        nv = 0;
        for (int t = 0; t < 40; t++) begin
            if (t == 3) line[0] = 1'b1;
            @(negedge clk);
            nb += int'(bsy[0]);
            nv += int'(vld[0]);
        end
        chk("fs_busy_seen", 32'(nb > 0), 1);
        chk("fs_busy_max", 32'(nb <= 8), 1);
        chk("fs_no_valid", 32'(nv), 0);

        // Overrun: consumer stalled across two frames
        rdy[0] = 1'b0;
        send_frame(0, 9'h011, 1'b0, 2'b11, 1'b1, -1);
        @(negedge clk);
        chk("ovr_first", 32'(dd[0]), 'h11);
        send_frame(0, 9'h022, 1'b0, 2'b11, 1'b1, -1);
        chk("ovr_pre", 32'(ovr[0]), 0);
        @(negedge clk);
        chk("ovr_pulse", 32'(ovr[0]), 1);
        chk("ovr_keep", 32'(dd[0]), 'h11);
        @(negedge clk);
        chk("ovr_one_cycle", 32'(ovr[0]), 0);
        chk("ovr_still_valid", 32'(vld[0]), 1);
        rdy[0] = 1'b1;
        @(negedge clk);
        chk("ovr_drain", 32'(vld[0]), 0);

        // Glitch on data bit 3 of 0x00 is outvoted
        repeat (3) @(negedge clk);
        send_frame(0, 9'h000, 1'b0, 2'b11, 1'b1, 3);
        @(negedge clk);
        chk("glitch_valid", 32'(vld[0]), 1);
        chk("glitch_data", 32'(dd[0]), 0);

        // Reset in the middle of a frame while a word is held
        repeat (3) @(negedge clk);
        rdy[0] = 1'b0;
        send_frame(0, 9'h05A, 1'b0, 2'b11, 1'b1, -1);
        @(negedge clk);
        chk("held_data", 32'(dd[0]), 'h5A);
        fork
            send_frame(0, 9'h0F0, 1'b0, 2'b11, 1'b0, -1);
            begin
                repeat (66) @(negedge clk);
                chk("pre_rst_busy", 32'(bsy[0]), 1);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                chk("rst_valid", 32'(vld[0]), 0);
                chk("rst_data", 32'(dd[0]), 0);
                chk("rst_busy", 32'(bsy[0]), 0);
                chk("rst_flags", 32'({fe[0], pe[0], ovr[0]}), 0);
            end
        join
        rdy[0] = 1'b1;
        repeat (3) @(negedge clk);
        send_frame(0, 9'h0C3, 1'b0, 2'b11, 1'b1, -1);
        @(negedge clk);
        chk("after_rst_valid", 32'(vld[0]), 1);
        chk("after_rst_data", 32'(dd[0]), 'hC3);
        repeat (5) @(negedge clk);
        chk("model_drained", 32'(pq.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Parametrised UART receiver, the next generation of the team's fixed 8N1 receiver. Data width, parity mode, stop-bit count and baud rate are set by parameters. Each bit is recovered by a 3-sample majority vote at mid-bit, and framing and parity errors are flagged. Received words go out on a valid/ready interface with overrun detection, so the block can feed a FIFO or the SDRAM command path directly.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz
BAUD, 9600, line rate in bit/s; BAUD_DIV = CLK_FREQ/BAUD (must be at least 8), MID = BAUD_DIV/2
DATA_BITS, 8, payload bits per frame, legal range 5..9
PARITY, 0, parity mode: 0 none, 1 odd, 2 even
STOP_BITS, 1, stop bits per frame: 1 or 2

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
uart_rx  input  1  asynchronous serial line, idle high
rx_data  output  DATA_BITS  received word, LSB = first bit on the line
rx_valid  output  1  rx_data and the error flags hold a word
rx_ready  input  1  consumer accepts the word when rx_valid && rx_ready
frame_err  output  1  a stop bit of the held word sampled low
parity_err  output  1  parity mismatch on the held word (always 0 when PARITY=0)
overrun  output  1  one-cycle pulse: a completed frame was dropped
busy  output  1  receiver FSM not in IDLE

Behaviour:
- One clock domain; rst is sampled on posedge clk only.
- Reset values: rx_data=0, rx_valid=0, frame_err=0, parity_err=0, overrun=0, busy=0, FSM=IDLE. Synchroniser flops reset to 1.
- Input path: 2-flop synchroniser followed by a history register. Start edge = sync value 0 while the previous value was 1.
- Bit timing: baud counter runs 0..BAUD_DIV-1 and clears on a start edge and on every state change.
- Majority vote samples at counts MID-1, MID, MID+1. The bit value is the majority of the three, resolved at count MID+1.
- FSM states: IDLE, START, DATA, PAR, STOP, DONE.
  - IDLE -> START on start edge.
  - START: voted bit 1 = false start -> IDLE with no output. Voted bit 0 -> DATA at the end of the bit period.
  - DATA: shift DATA_BITS bits LSB-first. Bit index counts 0..DATA_BITS-1, then go to PAR if PARITY!=0, else to STOP.
  - PAR: compare the voted bit with the expected parity. Odd: XOR of data and parity bit = 1. Even: that XOR = 0.
  - STOP: vote each stop bit; any 0 sets the pending frame error. After the last stop bit's vote (count MID+1), go to DONE without waiting for the end of the bit, so the next start edge is caught.
  - DONE: one cycle, output transfer, then -> IDLE.
- Output transfer in DONE:
  - If rx_valid=0, or rx_valid && rx_ready this cycle: load rx_data, frame_err and parity_err; rx_valid=1.
  - Otherwise: the new frame is dropped, held data and flags are unchanged, overrun=1 for exactly this cycle.
- Handshake: rx_valid falls the cycle after rx_valid && rx_ready, unless DONE loads a new word that same cycle; then rx_valid stays 1 with the new data. rx_data and the flags stay stable while rx_valid=1 and rx_ready=0.
- Latency: rx_valid rises 2 cycles after the last stop bit's vote cycle (1 cycle to DONE, 1 cycle registered).
- A start edge seen during DONE or outside IDLE is ignored. A line held low after a frame does not re-trigger until a 1 is seen.
- Reset mid-frame: immediate return to IDLE, all outputs at their reset values, partial frame discarded.
- busy=1 in every state except IDLE.

Test Plan:
- Bench setup: CLK_FREQ=1_000_000, BAUD=100_000 (BAUD_DIV=10), rx_ready=1 unless stated.
- 8N1 frame 0xA5 -> rx_data=0xA5, rx_valid high for 1 cycle, frame_err=0, parity_err=0, overrun=0.
- PARITY=2, DATA_BITS=7, send 0x35 with parity bit 1 -> parity_err=1. Resend with parity bit 0 -> parity_err=0, rx_data=0x35.
- STOP_BITS=2, second stop bit driven low, byte 0x3C -> rx_data=0x3C, frame_err=1. Next good frame clears frame_err.
- Start bit low for only 3 cycles, then high -> returns to IDLE, rx_valid never asserts, busy high for at most 8 cycles.
- rx_ready=0, send 0x11 then 0x22 -> rx_data stays 0x11, one-cycle overrun pulse at the end of the second frame. Raise rx_ready -> rx_valid falls the next cycle.
- 1-cycle glitch in the middle of data bit 3 of 0x00, plus rst pulsed during a later frame -> glitch rejected, rx_data=0x00. After rst: all outputs 0, next frame received correctly.
